gmii_rx_frame_check: RTL and testbench

- Sits directly downstream of the GMII/RGMII converter, in the gmii_rx_clk domain. Consumes gmii_rx_dv/gmii_rxd.
- Strips the preamble and SFD, filters on destination MAC, and checks CRC-32, runt and oversize conditions.
- Emits frame bytes (destination MAC through payload, FCS removed) as a byte stream with sop/eop, a status word and frame statistics for the UDP/packet layers above.

---
 rtl/gmii_rx_frame_check.sv | 185 ++++++++++++++++++
 tb/tb_gmii_rx_frame_check.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_frame_check.sv
// GMII receive frame checker: strips preamble/SFD, filters on destination MAC,
// checks CRC-32, runt and oversize, and streams frame bytes with the FCS removed.
module gmii_rx_frame_check #(
   parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55,
   parameter bit          BCAST_EN  = 1'b1,
   parameter int          MAX_LEN   = 1518
) (
   input  logic        gmii_rx_clk,
   input  logic        rst,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   output logic        rx_sop,
   output logic        rx_eop,
   output logic [2:0]  rx_err,
   output logic        rx_good,
   output logic [10:0] rx_len,
   output logic [15:0] ok_cnt,
   output logic [15:0] err_cnt
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PREAMBLE = 3'd1;
   localparam logic [2:0] S_FRAME    = 3'd2;
   localparam logic [2:0] S_DROP     = 3'd3;
   localparam logic [2:0] S_FLUSH    = 3'd4;

   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [10:0] MAX_N       = 11'(MAX_LEN);

   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      return r;
   endfunction

   // Destination byte k (1..6) of the station address, first received first.
   function automatic logic [7:0] mac_byte(input logic [2:0] k);
      logic [7:0] b;
      case (k)
         3'd1:    b = LOCAL_MAC[47:40];
         3'd2:    b = LOCAL_MAC[39:32];
         3'd3:    b = LOCAL_MAC[31:24];
         3'd4:    b = LOCAL_MAC[23:16];
         3'd5:    b = LOCAL_MAC[15:8];
         default: b = LOCAL_MAC[7:0];
      endcase
      return b;
   endfunction

   logic [2:0]  state;
   logic        dv_d;
   logic [2:0]  pre_cnt;
   logic [10:0] n;
   logic [31:0] crc;
   logic        ucast_hit;
   logic        bcast_hit;
   logic [7:0]  dly [5];

   logic [10:0] n_inc;
   logic [31:0] crc_upd;
   logic        ucast_next;
   logic        bcast_next;
   logic [2:0]  err_vec;

   always_comb begin
      n_inc      = (n == 11'h7FF) ? n : n + 11'd1;
      crc_upd    = crc_next(crc, gmii_rxd);
      ucast_next = ucast_hit & (gmii_rxd == mac_byte(n_inc[2:0]));
      bcast_next = bcast_hit & (gmii_rxd == 8'hFF);
      err_vec    = {n > MAX_N, n < 11'd64, crc != CRC_RESIDUE};
   end

   // The output register adds the sixth stage, so byte k leaves six cycles after arrival.
   // NOTE: the delay line is pure data gated by state, so it needs no reset.
   always_ff @(posedge gmii_rx_clk) begin
      dly[0] <= gmii_rxd;
      for (int i = 4; i > 0; i--)
         dly[i] <= dly[i-1];
   end

   always_ff @(posedge gmii_rx_clk) begin
      if (rst) begin
         state     <= S_IDLE;
         dv_d      <= 1'b1;
         pre_cnt   <= 3'd0;
         n         <= 11'd0;
         crc       <= 32'hFFFF_FFFF;
         ucast_hit <= 1'b0;
         bcast_hit <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= 8'd0;
         rx_sop    <= 1'b0;
         rx_eop    <= 1'b0;
         rx_err    <= 3'd0;
         rx_good   <= 1'b0;
         rx_len    <= 11'd0;
         ok_cnt    <= 16'd0;
         err_cnt   <= 16'd0;
      end else begin
         dv_d     <= gmii_rx_dv;
         rx_valid <= 1'b0;
         rx_data  <= 8'd0;
         rx_sop   <= 1'b0;
         rx_eop   <= 1'b0;
         rx_err   <= 3'd0;
         rx_good  <= 1'b0;
         rx_len   <= 11'd0;

         case (state)
            S_IDLE: begin
               if (gmii_rx_dv) begin
                  if (!dv_d && gmii_rxd == 8'h55) begin
                     state   <= S_PREAMBLE;
                     pre_cnt <= 3'd1;
                  end else begin
                     state <= S_DROP;
                  end
               end
            end

            S_PREAMBLE: begin
               if (!gmii_rx_dv) begin
                  state <= S_IDLE;
               end else if (gmii_rxd == 8'h55) begin
                  if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
               end else if (gmii_rxd == 8'hD5 && pre_cnt >= 3'd6) begin
                  state     <= S_FRAME;
                  n         <= 11'd0;
                  crc       <= 32'hFFFF_FFFF;
                  ucast_hit <= 1'b1;
                  bcast_hit <= BCAST_EN;
               end else begin
                  state <= S_DROP;
               end
            end

            S_FRAME: begin
               if (gmii_rx_dv) begin
                  n   <= n_inc;
                  crc <= crc_upd;
                  if (n_inc <= 11'd6) begin
                     ucast_hit <= ucast_next;
                     bcast_hit <= bcast_next;
                     if (!(ucast_next || bcast_next)) begin
                        state <= S_DROP;
                     end else if (n_inc == 11'd6) begin
                        rx_valid <= 1'b1;
                        rx_sop   <= 1'b1;
                        rx_data  <= dly[4];
                     end
                  end else begin
                     rx_valid <= 1'b1;
                     rx_data  <= dly[4];
                  end
               end else if (n <= 11'd6) begin
                  state <= S_IDLE;
               end else begin
                  // First dv-low cycle: the tail of the delay line holds byte N-4.
                  rx_valid <= 1'b1;
                  rx_data  <= dly[4];
                  rx_eop   <= 1'b1;
                  rx_err   <= err_vec;
                  rx_good  <= (err_vec == 3'd0);
                  rx_len   <= n - 11'd4;
                  if (err_vec == 3'd0) ok_cnt  <= ok_cnt + 16'd1;
                  else                 err_cnt <= err_cnt + 16'd1;
                  state <= S_FLUSH;
               end
            end

            S_FLUSH: state <= gmii_rx_dv ? S_DROP : S_IDLE;

            S_DROP: if (!gmii_rx_dv) state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// Bench for gmii_rx_frame_check: directed table, hand-written corner sequences and
// random frames scored against a frame-level reference model.
module tb_gmii_rx_frame_check;

   localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;

   typedef logic [7:0] bq_t [$];

   typedef struct {
      int         pre;
      logic [7:0] sfd;
      bit         lead_bad;
      int         dest;      // 0 local, 1 broadcast, 2 local with last byte 0x56, 3 foreign
      int         n;
      bit         corrupt;
      bit         raw;       // no FCS appended
      bit         acc;
      logic [2:0] err;
      int         len;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dv  = 1'b0;
   logic [7:0]  rxd = 8'd0;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_sop;
   logic        rx_eop;
   logic [2:0]  rx_err;
   logic        rx_good;
   logic [10:0] rx_len;
   logic [15:0] ok_cnt;
   logic [15:0] err_cnt;

   always #4 clk = ~clk;

   gmii_rx_frame_check dut (
      .gmii_rx_clk (clk),
      .rst         (rst),
      .gmii_rx_dv  (dv),
      .gmii_rxd    (rxd),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_sop      (rx_sop),
      .rx_eop      (rx_eop),
      .rx_err      (rx_err),
      .rx_good     (rx_good),
      .rx_len      (rx_len),
      .ok_cnt      (ok_cnt),
      .err_cnt     (err_cnt)
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   int          tick_no = 0;
   logic [15:0] exp_ok = 16'd0;
   logic [15:0] exp_errc = 16'd0;

   bq_t         got;
   int          n_sop, sop_tick, n_eop, eop_tick, stray;
   logic [2:0]  eop_err;
   logic [10:0] eop_len;
   logic        eop_good;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      got.delete();
      n_sop = 0; sop_tick = -1; n_eop = 0; eop_tick = -1; stray = 0;
      eop_err = 3'd0; eop_len = 11'd0; eop_good = 1'b0;
   endtask

   // Drive one cycle just after the rising edge, then sample outputs on the falling edge.
   task automatic tick(input logic r, input logic v, input logic [7:0] d);
      @(posedge clk);
      #1;
      rst = r; dv = v; rxd = d;
      tick_no++;
      @(negedge clk);
      if (rx_valid) got.push_back(rx_data);
      if (rx_sop) begin n_sop++; sop_tick = tick_no; end
      if (rx_eop) begin
         n_eop++; eop_tick = tick_no;
         eop_err = rx_err; eop_len = rx_len; eop_good = rx_good;
      end else if (rx_err != 3'd0 || rx_good) begin
         stray++;
      end
      if ((rx_sop || rx_eop) && !rx_valid) stray++;
   endtask

   function automatic logic [31:0] crc_reg(input bq_t q);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      foreach (q[i]) begin
         c = c ^ {24'd0, q[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   task automatic build_frame(input int dest, input int n, input bit corrupt, input bit raw,
                              output bq_t f);
      logic [47:0] src;
      logic [31:0] fcs;
      int          target;
      src    = 48'h02_AA_BB_CC_DD_EE;
      target = raw ? n : n - 4;
      f.delete();
      for (int i = 0; i < 6; i++) begin
         case (dest)
            0:       f.push_back(MAC[47-8*i -: 8]);
            1:       f.push_back(8'hFF);
            2:       f.push_back((i == 5) ? 8'h56 : MAC[47-8*i -: 8]);
            default: f.push_back((i == 0) ? 8'h02 : 8'($urandom));
         endcase
      end
      for (int i = 0; i < 6; i++)
         if (f.size() < target) f.push_back(src[47-8*i -: 8]);
      while (f.size() < target) f.push_back(8'($urandom));
      if (!raw) begin
         fcs = ~crc_reg(f);
         for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
      end
      if (corrupt) f[20] = f[20] ^ 8'h08;
   endtask

   task automatic build_burst(input int pre, input logic [7:0] sfd, input bit lead_bad,
                              input bq_t f, output bq_t burst, output int start);
      burst.delete();
      if (lead_bad) burst.push_back(8'h5D);
      for (int i = 0; i < pre; i++) burst.push_back(8'h55);
      burst.push_back(sfd);
      start = burst.size();
      foreach (f[i]) burst.push_back(f[i]);
   endtask

   // Frame-level reference: what a receiver should deliver for one dv-high burst.
   task automatic model(input bq_t burst, output bit acc, output bq_t data,
                        output logic [2:0] err, output int len);
      bq_t         frame;
      int          i, n;
      bit          uc, bc, fcs_ok;
      logic [31:0] fcs;
      acc = 0; data.delete(); err = 3'd0; len = 0;
      if (burst.size() == 0 || burst[0] != 8'h55) return;
      i = 0;
      while (i < burst.size() && burst[i] == 8'h55) i++;
      if (i >= burst.size() || burst[i] != 8'hD5 || i < 6) return;
      for (int k = i + 1; k < burst.size(); k++) frame.push_back(burst[k]);
      n = frame.size();
      if (n < 7) return;
      uc = 1; bc = 1;
      for (int k = 0; k < 6; k++) begin
         uc = uc && (frame[k] == MAC[47-8*k -: 8]);
         bc = bc && (frame[k] == 8'hFF);
      end
      if (!(uc || bc)) return;
      acc = 1;
      for (int k = 0; k < n - 4; k++) data.push_back(frame[k]);
      fcs    = ~crc_reg(data);
      fcs_ok = (frame[n-4] == fcs[7:0])   && (frame[n-3] == fcs[15:8]) &&
               (frame[n-2] == fcs[23:16]) && (frame[n-1] == fcs[31:24]);
      err = {n > 1518, n < 64, !fcs_ok};
      len = (n - 4) & 11'h7FF;
   endtask

   task automatic run_burst(input string tag, input bq_t burst, input int start,
                            input bit acc, input bq_t exp_data, input logic [2:0] err,
                            input int len);
      int b1, n, bad;
      clear_mon();
      b1 = -1;
      foreach (burst[k]) begin
         tick(1'b0, 1'b1, burst[k]);
         if (k == start) b1 = tick_no;
      end
      for (int g = 0; g < 12; g++) tick(1'b0, 1'b0, 8'h00);
      if (acc) begin
         if (err == 3'd0) exp_ok++;
         else             exp_errc++;
         n   = burst.size() - start;
         bad = -1;
         for (int k = 0; k < got.size() && k < exp_data.size(); k++)
            if (got[k] !== exp_data[k] && bad < 0) bad = k;
         check({tag, " byte_count"}, got.size(), exp_data.size());
         check({tag, " first_bad_byte"}, bad, -1);
         check({tag, " sop_count"}, n_sop, 1);
         check({tag, " sop_latency"}, sop_tick - b1, 6);
         check({tag, " eop_count"}, n_eop, 1);
         check({tag, " eop_cycle"}, eop_tick - b1, n + 1);
         check({tag, " rx_err"}, eop_err, err);
         check({tag, " rx_len"}, eop_len, len);
         check({tag, " rx_good"}, eop_good, err == 3'd0);
      end else begin
         check({tag, " byte_count"}, got.size(), 0);
         check({tag, " eop_count"}, n_eop, 0);
      end
      check({tag, " stray_status"}, stray, 0);
      check({tag, " ok_cnt"}, ok_cnt, exp_ok);
      check({tag, " err_cnt"}, err_cnt, exp_errc);
   endtask

   vec_t tbl[15];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bq_t        f, f2, burst, burst2, exp_data;
      int         start, start2, cnt_at_rst, n_before;
      bit         acc;
      logic [2:0] err;
      int         len;

      tbl[0]  = '{7, 8'hD5, 0, 0,   64, 0, 0, 1, 3'b000,   60};
      tbl[1]  = '{7, 8'hD5, 0, 0,   64, 1, 0, 1, 3'b001,   60};
      tbl[2]  = '{7, 8'hD5, 0, 2,   64, 0, 0, 0, 3'b000,    0};
      tbl[3]  = '{7, 8'hD5, 0, 1,   64, 0, 0, 1, 3'b000,   60};
      tbl[4]  = '{7, 8'hD5, 0, 0,   40, 0, 0, 1, 3'b010,   36};
      tbl[5]  = '{7, 8'hD5, 0, 0, 1522, 0, 0, 1, 3'b100, 1518};
      tbl[6]  = '{4, 8'hD5, 0, 0,   64, 0, 0, 0, 3'b000,    0};
      tbl[7]  = '{7, 8'hD5, 1, 0,   64, 0, 0, 0, 3'b000,    0};
      tbl[8]  = '{7, 8'hD5, 0, 0,   64, 0, 0, 1, 3'b000,   60};
      tbl[9]  = '{6, 8'hD5, 0, 0,   63, 0, 0, 1, 3'b010,   59};
      tbl[10] = '{7, 8'hD5, 0, 0, 1518, 0, 0, 1, 3'b000, 1514};
      tbl[11] = '{7, 8'hD5, 0, 0, 1519, 0, 0, 1, 3'b100, 1515};
      tbl[12] = '{7, 8'hD5, 0, 0,    7, 0, 1, 1, 3'b011,    3};
      tbl[13] = '{9, 8'hD5, 0, 1,  100, 1, 0, 1, 3'b001,   96};
      tbl[14] = '{7, 8'hD4, 0, 0,   64, 0, 0, 0, 3'b000,    0};

      // Reset state.
      clear_mon();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 8'h00);
      check("reset rx_valid", rx_valid, 0);
      check("reset rx_sop_eop_good", {rx_sop, rx_eop, rx_good}, 0);
      check("reset rx_err", rx_err, 0);
      check("reset rx_len", rx_len, 0);
      check("reset rx_data", rx_data, 0);
      check("reset ok_cnt", ok_cnt, 0);
      check("reset err_cnt", err_cnt, 0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00);

      // Directed table.
      foreach (tbl[t]) begin
         build_frame(tbl[t].dest, tbl[t].n, tbl[t].corrupt, tbl[t].raw, f);
         build_burst(tbl[t].pre, tbl[t].sfd, tbl[t].lead_bad, f, burst, start);
         exp_data.delete();
         if (tbl[t].acc)
            for (int k = 0; k < tbl[t].len; k++) exp_data.push_back(f[k]);
         run_burst($sformatf("vec%0d", t), burst, start, tbl[t].acc, exp_data,
                   tbl[t].err, tbl[t].len);
      end

      // dv rising again one cycle after a frame ends: first frame kept, second dropped.
      build_frame(0, 64, 0, 0, f);
      build_burst(7, 8'hD5, 0, f, burst, start);
      build_frame(0, 64, 0, 0, f2);
      build_burst(7, 8'hD5, 0, f2, burst2, start2);
      clear_mon();
      foreach (burst[k]) tick(1'b0, 1'b1, burst[k]);
      tick(1'b0, 1'b0, 8'h00);
      foreach (burst2[k]) tick(1'b0, 1'b1, burst2[k]);
      for (int g = 0; g < 12; g++) tick(1'b0, 1'b0, 8'h00);
      exp_ok++;
      check("flush byte_count", got.size(), 60);
      check("flush eop_count", n_eop, 1);
      check("flush rx_len", eop_len, 60);
      check("flush ok_cnt", ok_cnt, exp_ok);

      // Reset at frame byte 30 with dv held high; the rest of the frame must be ignored.
      build_frame(0, 100, 0, 0, f);
      build_burst(7, 8'hD5, 0, f, burst, start);
      clear_mon();
      cnt_at_rst = -1;
      foreach (burst[k]) begin
         tick(k == start + 29, 1'b1, burst[k]);
         if (k == start + 29) cnt_at_rst = got.size();
         if (k == start + 30) begin
            check("rst_mid outputs_zero",
                  {rx_valid, rx_sop, rx_eop, rx_good, rx_err, rx_len, rx_data}, 0);
            check("rst_mid counters_zero", {ok_cnt, err_cnt}, 0);
         end
      end
      for (int g = 0; g < 12; g++) tick(1'b0, 1'b0, 8'h00);
      exp_ok = 16'd0; exp_errc = 16'd0;
      check("rst_mid no_bytes_after_reset", got.size(), cnt_at_rst);
      check("rst_mid eop_count", n_eop, 0);
      check("rst_mid ok_cnt", ok_cnt, exp_ok);
      build_frame(0, 64, 0, 0, f);
      build_burst(7, 8'hD5, 0, f, burst, start);
      model(burst, acc, exp_data, err, len);
      run_burst("after_rst", burst, start, acc, exp_data, err, len);

      // Random frames against the reference model.
      for (int r = 0; r < 24; r++) begin
         int d, n, pre;
         bit corrupt, lead;
         pre     = 4 + $urandom_range(0, 5);
         lead    = ($urandom_range(0, 9) == 0);
         d       = ($urandom_range(0, 3) == 0) ? 2 + $urandom_range(0, 1) : $urandom_range(0, 1);
         n       = $urandom_range(58, 200);
         corrupt = ($urandom_range(0, 3) == 0);
         build_frame(d, n, corrupt, 0, f);
         build_burst(pre, 8'hD5, lead, f, burst, start);
         model(burst, acc, exp_data, err, len);
         n_before = n_cmp;
         run_burst($sformatf("rand%0d", r), burst, start, acc, exp_data, err, len);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
